// File: rtl/vesp_mem_port.sv
// vesp_mem_port: VeSP main-memory block with req/ready/rvalid handshake,
// configurable read latency, opa/opb operand shadows of words 0 and 1,
// and an out-of-range access flag.
// Optional feature macro: VESP_MEM_PARITY_EN (per-word even parity + perr_o).
module vesp_mem_port #(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o,
`ifdef VESP_MEM_PARITY_EN
  output logic              perr_o,
`endif
  output logic [WORD_W-1:0] opa_o,
  output logic [WORD_W-1:0] opb_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(READ_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // FSM state and read bookkeeping
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               rd_oor_q, rd_oor_d;

  // registered outputs
  logic               ready_q, ready_d;
  logic               rvalid_q, rvalid_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [WORD_W-1:0]  opa_q, opa_d;
  logic [WORD_W-1:0]  opb_q, opb_d;

  // handshake strobes decoded from the FSM
  logic               wr_acc;
  logic               rd_acc;
  logic               rd_done;

  // address decode
  logic               addr_oor;
  logic [IDX_W-1:0]   addr_idx;
  logic               addr_is0;
  logic               addr_is1;

  // storage
  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [WORD_W-1:0]  mem_rd_word;

`ifdef VESP_MEM_PARITY_EN
  logic               par_q [DEPTH];
  logic               par_rd_bit;
  logic               perr_q, perr_d;
`endif

  // Unsigned full-width range compare; extra MSB lets DEPTH == 2**ADDR_W work.
  always_comb begin
    addr_oor = ({1'b0, addr_i} >= DEPTH_EXT);
    addr_idx = addr_i[IDX_W-1:0];
    addr_is0 = (addr_i == ADDR_W'(0));
    addr_is1 = (addr_i == ADDR_W'(1));
  end

  // Read port of the storage array, addressed by the latched read index.
  always_comb begin
    mem_rd_word = mem_q[rd_idx_q];
`ifdef VESP_MEM_PARITY_EN
    par_rd_bit  = par_q[rd_idx_q];
`endif
  end

  // FSM state register; reset aborts any pending read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: reads park in WAIT until the latency counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_i && !we_i) state_d = S_WAIT;
      S_WAIT: if (cnt_q == '0)    state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // FSM output decode: requests are only seen in IDLE; WAIT ignores req.
  always_comb begin
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_acc = req_i && we_i;
        rd_acc = req_i && !we_i;
      end
      S_WAIT: begin
        rd_done = (cnt_q == '0);
      end
      default: begin
        wr_acc  = 1'b0;
      end
    endcase
  end

  // Datapath next-state: latency counter, read latch, output pulses and shadows.
  always_comb begin
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    rd_oor_d = rd_oor_q;
    ready_d  = (state_d == S_IDLE);
    rvalid_d = rd_done;
    err_d    = (wr_acc && addr_oor) || (rd_done && rd_oor_q);
    rdata_d  = rdata_q;
    opa_d    = opa_q;
    opb_d    = opb_q;

    if (rd_acc) begin
      cnt_d    = CNT_LOAD;
      rd_idx_d = addr_idx;
      rd_oor_d = addr_oor;
    end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (rd_done) begin
      rdata_d = rd_oor_q ? '0 : mem_rd_word;
    end

    // Words 0 and 1 are always in range, so the shadows track every write to them.
    if (wr_acc && addr_is0) begin
      opa_d = wdata_i;
    end
    if (wr_acc && addr_is1) begin
      opb_d = wdata_i;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rd_idx_q <= '0;
      rd_oor_q <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
      rd_oor_q <= rd_oor_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  // Storage write; out-of-range writes are dropped. Contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !addr_oor) begin
      mem_q[addr_idx] <= wdata_i;
    end
  end

`ifdef VESP_MEM_PARITY_EN
  // Even-parity bit stored alongside each word.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !addr_oor) begin
      par_q[addr_idx] <= ^wdata_i;
    end
  end

  // Parity error accompanies rvalid; out-of-range reads never flag it.
  always_comb begin
    perr_d = rd_done && !rd_oor_q && ((^mem_rd_word) != par_rd_bit);
  end

  // Parity error output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign perr_o = perr_q;
`endif

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign opa_o    = opa_q;
  assign opb_o    = opb_q;

endmodule
